rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles all resets stay asserted after a reset trigger.
REQ-002 Parameter STAGE_DLY, default 4: cycles between successive domain releases.
REQ-003 Parameter DEB_CYCLES, default 8: cycles ext_rst_n_i must be stable before a level change is accepted.
REQ-004 clk  input  1  single system clock; all logic in this one domain.
REQ-005 arst_i  input  1  reset, asynchronous, active-low; asserts every output immediately.
REQ-006 ext_rst_n_i  input  1  external reset button, asynchronous to clk, active-low, may bounce.
REQ-007 sw_rst_req_i  input  1  software reset request, one-cycle synchronous pulse.
REQ-008 wdt_rst_req_i  input  1  watchdog reset request, one-cycle synchronous pulse.
REQ-009 rst_bus_o  output  1  bus/interconnect reset, active-low, synchronous deassert.
REQ-010 rst_periph_o  output  1  peripheral reset, active-low, synchronous deassert.
REQ-011 rst_cpu_o  output  1  CPU reset, active-low, synchronous deassert.
REQ-012 rst_done_o  output  1  high when all domains released.
REQ-013 rst_cause_o  output  2  last reset cause: 0 POR, 1 EXT, 2 SW, 3 WDT.

Function
REQ-014 States: HOLD, REL_BUS, REL_PERIPH, REL_CPU, RUN; one down-counter, width for max(HOLD_CYCLES, STAGE_DLY).
REQ-015 HOLD: all three resets low; after HOLD_CYCLES edges -> REL_BUS, rst_bus_o registered high.
REQ-016 REL_BUS: after STAGE_DLY edges -> REL_PERIPH, rst_periph_o high.
REQ-017 REL_PERIPH: after STAGE_DLY edges -> REL_CPU, rst_cpu_o high; same edge -> RUN, rst_done_o high.
REQ-018 Release order bus, periph, cpu; a later domain never deasserts before an earlier one.
REQ-019 All outputs registered; no combinational path from any input to an output except async assertion by arst_i.
REQ-020 ext_rst_n_i passes through 2-flop synchronizer, then debouncer; debounced falling edge is an EXT trigger.
REQ-021 While debounced ext level is low, state held in HOLD with counter reloaded; hold count begins on debounced release.
REQ-022 Trigger (EXT, SW, WDT) in any state: next edge -> HOLD, all resets low, counter reloaded, rst_done_o low.
REQ-023 Trigger during HOLD restarts the full HOLD_CYCLES count.
REQ-024 Simultaneous triggers: cause priority WDT > EXT > SW; one restart only.
REQ-025 rst_cause_o updates on the trigger edge; holds until next trigger or arst_i.
REQ-026 Glitch shorter than DEB_CYCLES on synchronized ext input: no trigger, no state change.
REQ-027 sw/wdt pulses are acted on in every state, including RUN.

Reset
REQ-028 arst_i low: state HOLD, counter = HOLD_CYCLES, rst_bus_o/rst_periph_o/rst_cpu_o = 0, rst_done_o = 0, rst_cause_o = 0 (POR), synchronizer flops and debounced level = 1 (released).
REQ-029 arst_i assertion mid-sequence or in RUN aborts immediately, asynchronously; no partial release.
REQ-030 Sequence after arst_i release identical to any other trigger, counting from first clk edge with arst_i high.

Structure
REQ-031 Shared package holds cause encodings (POR/EXT/SW/WDT) and state encoding constants.
REQ-032 Debounce logic is one sub-module, rst_debounce (sync 2-flop + stability counter, parameter DEB_CYCLES, output debounced level).
REQ-033 Sequencer FSM, counter and cause register in rst_seq top.

Verification (HOLD=16, STAGE=4, DEB=8)
REQ-034 Release arst_i, inputs idle -> rst_bus_o high edge 16, rst_periph_o edge 20, rst_cpu_o and rst_done_o edge 24; rst_cause_o=0.
REQ-035 In RUN pulse sw_rst_req_i -> next edge all resets low, cause=2; rst_done_o re-asserts 24 edges later.
REQ-036 ext_rst_n_i low 5 cycles, bouncing -> no trigger; held low 30 cycles -> trigger, cause=1, hold count starts after debounced release.
REQ-037 sw and wdt pulses same cycle during REL_PERIPH -> cause=3, rst_bus_o drops, full 24-edge sequence restarts.
REQ-038 arst_i low mid REL_BUS -> all outputs low with no clock edge; cause=0.
REQ-039 wdt pulse at HOLD count 3 -> HOLD restarts, rst_bus_o rises 16 edges after pulse edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg -- shared definitions for the reset sequencer.
//   state_e : sequencer state encoding
//   cause_e : reset cause encoding reported on rst_cause_o
//   max_int : helper used to size the shared down-counter
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_REL_BUS    = 3'd1,
        ST_REL_PERIPH = 3'd2,
        ST_REL_CPU    = 3'd3,
        ST_RUN        = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_EXT = 2'd1,
        CAUSE_SW  = 2'd2,
        CAUSE_WDT = 2'd3
    } cause_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_debounce.sv
// rst_debounce -- synchronizes and debounces the external reset button.
//   clk         : system clock
//   arst_i      : async active-low reset; forces everything to "released" (1)
//   async_i     : raw button level, asynchronous to clk, active-low
//   level_o     : debounced level; changes only after DEB_CYCLES stable cycles
module rst_debounce
#(
    parameter int DEB_CYCLES = 8
)
(
    input  logic clk,
    input  logic arst_i,
    input  logic async_i,
    output logic level_o
);

    localparam int DEB_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge arst_i) begin
        if (!arst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            // Any return to the accepted level restarts the stability window.
            if (sync2_q != level_q) begin
                if (cnt_q == DEB_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + DEB_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/rst_seq.sv
// rst_seq -- staged reset sequencer (bus -> periph -> cpu).
//   clk           : system clock
//   arst_i        : async active-low reset, asserts all resets immediately
//   ext_rst_n_i   : external reset button, async, active-low, may bounce
//   sw_rst_req_i  : software reset request pulse
//   wdt_rst_req_i : watchdog reset request pulse
//   rst_bus_o     : bus reset, active-low
//   rst_periph_o  : peripheral reset, active-low
//   rst_cpu_o     : CPU reset, active-low
//   rst_done_o    : high once every domain is released
//   rst_cause_o   : last reset cause (POR/EXT/SW/WDT)
//
// state         | meaning
// ST_HOLD       | all resets asserted, counting HOLD_CYCLES
// ST_REL_BUS    | bus released, counting STAGE_DLY
// ST_REL_PERIPH | bus+periph released, counting STAGE_DLY
// ST_REL_CPU    | cpu release point; passed through on the same edge as RUN
// ST_RUN        | all domains released
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_DLY   = 4,
    parameter int DEB_CYCLES  = 8
)
(
    input  logic       clk,
    input  logic       arst_i,
    input  logic       ext_rst_n_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_rst_req_i,
    output logic       rst_bus_o,
    output logic       rst_periph_o,
    output logic       rst_cpu_o,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGE_DLY) + 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STAGE_LD = CNT_W'(STAGE_DLY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_q, periph_q, cpu_q, done_q;
    cause_e           cause_q;
    logic             ext_prev_q;

    logic             ext_lvl;
    logic             ext_fall;
    logic             trig;
    cause_e           trig_cause;

    rst_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk     (clk),
        .arst_i  (arst_i),
        .async_i (ext_rst_n_i),
        .level_o (ext_lvl)
    );

    assign ext_fall = ext_prev_q & ~ext_lvl;
    assign trig     = ext_fall | sw_rst_req_i | wdt_rst_req_i;

    always_comb begin
        trig_cause = CAUSE_SW;
        if (wdt_rst_req_i)
            trig_cause = CAUSE_WDT;
        else if (ext_fall)
            trig_cause = CAUSE_EXT;
    end

    always_ff @(posedge clk or negedge arst_i) begin
        if (!arst_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= HOLD_LD;
            bus_q      <= 1'b0;
            periph_q   <= 1'b0;
            cpu_q      <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= CAUSE_POR;
            ext_prev_q <= 1'b1;
        end else begin
            ext_prev_q <= ext_lvl;
            if (trig || !ext_lvl) begin
                // A held button keeps reloading, so counting starts on release.
                state_q  <= ST_HOLD;
                cnt_q    <= HOLD_LD;
                bus_q    <= 1'b0;
                periph_q <= 1'b0;
                cpu_q    <= 1'b0;
                done_q   <= 1'b0;
                if (trig)
                    cause_q <= trig_cause;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_REL_BUS;
                            cnt_q   <= STAGE_LD;
                            bus_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_REL_BUS: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q  <= ST_REL_PERIPH;
                            cnt_q    <= STAGE_LD;
                            periph_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_REL_PERIPH: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_RUN;
                            cpu_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_REL_CPU: begin
                        state_q <= ST_RUN;
                        cpu_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_HOLD;
                        cnt_q   <= HOLD_LD;
                    end
                endcase
            end
        end
    end

    assign rst_bus_o    = bus_q;
    assign rst_periph_o = periph_q;
    assign rst_cpu_o    = cpu_q;
    assign rst_done_o   = done_q;
    assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq -- directed bench for rst_seq (HOLD=16, STAGE=4, DEB=8).
module tb_rst_seq;

    localparam int H = 16;
    localparam int S = 4;

    logic       clk;
    logic       arst_i;
    logic       ext_rst_n_i;
    logic       sw_rst_req_i;
    logic       wdt_rst_req_i;
    logic       rst_bus_o;
    logic       rst_periph_o;
    logic       rst_cpu_o;
    logic       rst_done_o;
    logic [1:0] rst_cause_o;

    int total = 0;
    int bad   = 0;

    rst_seq #(.HOLD_CYCLES(16), .STAGE_DLY(4), .DEB_CYCLES(8)) dut (
        .clk           (clk),
        .arst_i        (arst_i),
        .ext_rst_n_i   (ext_rst_n_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .wdt_rst_req_i (wdt_rst_req_i),
        .rst_bus_o     (rst_bus_o),
        .rst_periph_o  (rst_periph_o),
        .rst_cpu_o     (rst_cpu_o),
        .rst_done_o    (rst_done_o),
        .rst_cause_o   (rst_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {rst_bus_o, rst_periph_o, rst_cpu_o, rst_done_o};
    endfunction

    // Release pattern expected e edges after the sequence start, offset by off.
    function automatic logic [3:0] seq_exp(input int e, input int off);
        return {e >= off + H, e >= off + H + S, e >= off + H + 2*S, e >= off + H + 2*S};
    endfunction

    task automatic run_seq(input string name, input int n, input int off);
        for (int e = 1; e <= n; e++) begin
            tick();
            total++;
            if (outs() !== seq_exp(e, off)) begin
                bad++;
                $display("FAIL %s edge=%0d got=%b exp=%b", name, e, outs(), seq_exp(e, off));
            end
        end
    endtask

    task automatic test_reset();
        arst_i = 1'b1; ext_rst_n_i = 1'b1; sw_rst_req_i = 1'b0; wdt_rst_req_i = 1'b0;
        #2 arst_i = 1'b0;
        #1;
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_00) begin
            bad++;
            $display("FAIL reset_async got=%b/%0d exp=0000/0", outs(), rst_cause_o);
        end
        tick(); tick();
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_00) begin
            bad++;
            $display("FAIL reset_held got=%b/%0d exp=0000/0", outs(), rst_cause_o);
        end
    endtask

    task automatic test_por_seq();
        arst_i = 1'b1;
        run_seq("por_seq", 26, 0);
        total++;
        if (rst_cause_o !== 2'd0) begin
            bad++;
            $display("FAIL por_cause got=%0d exp=0", rst_cause_o);
        end
    endtask

    task automatic test_sw_in_run();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_10) begin
            bad++;
            $display("FAIL sw_trig got=%b/%0d exp=0000/2", outs(), rst_cause_o);
        end
        run_seq("sw_seq", 24, 0);
    endtask

    task automatic test_ext_glitch();
        ext_rst_n_i = 1'b0; tick(); tick();
        ext_rst_n_i = 1'b1; tick();
        ext_rst_n_i = 1'b0; tick(); tick();
        ext_rst_n_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({outs(), rst_cause_o} !== 6'b1111_10) begin
                bad++;
                $display("FAIL ext_glitch cyc=%0d got=%b/%0d exp=1111/2", i, outs(), rst_cause_o);
            end
        end
    endtask

    task automatic test_ext_hold();
        ext_rst_n_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (outs() !== 4'b1111) begin
            bad++;
            $display("FAIL ext_before_deb got=%b exp=1111", outs());
        end
        tick();
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_01) begin
            bad++;
            $display("FAIL ext_trig got=%b/%0d exp=0000/1", outs(), rst_cause_o);
        end
        for (int i = 0; i < 19; i++) tick();
        total++;
        if (outs() !== 4'b0000) begin
            bad++;
            $display("FAIL ext_held got=%b exp=0000", outs());
        end
        ext_rst_n_i = 1'b1;
        // 2 sync + 8 debounce edges before the hold count starts.
        run_seq("ext_release", 34, 10);
        total++;
        if (rst_cause_o !== 2'd1) begin
            bad++;
            $display("FAIL ext_cause got=%0d exp=1", rst_cause_o);
        end
    endtask

    task automatic test_simul_sw_wdt();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 21; i++) tick();
        total++;
        if (outs() !== 4'b1100) begin
            bad++;
            $display("FAIL simul_pre got=%b exp=1100", outs());
        end
        sw_rst_req_i = 1'b1; wdt_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0; wdt_rst_req_i = 1'b0;
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_11) begin
            bad++;
            $display("FAIL simul_trig got=%b/%0d exp=0000/3", outs(), rst_cause_o);
        end
        run_seq("simul_seq", 24, 0);
    endtask

    task automatic test_wdt_in_hold();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        tick(); tick(); tick();
        wdt_rst_req_i = 1'b1;
        tick();
        wdt_rst_req_i = 1'b0;
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_11) begin
            bad++;
            $display("FAIL wdt_hold_trig got=%b/%0d exp=0000/3", outs(), rst_cause_o);
        end
        run_seq("wdt_hold_seq", 24, 0);
    endtask

    task automatic test_arst_mid_rel_bus();
        sw_rst_req_i = 1'b1;
        tick();
        sw_rst_req_i = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        total++;
        if ({outs(), rst_cause_o} !== 6'b1000_10) begin
            bad++;
            $display("FAIL arst_pre got=%b/%0d exp=1000/2", outs(), rst_cause_o);
        end
        #2 arst_i = 1'b0;
        #1;
        total++;
        if ({outs(), rst_cause_o} !== 6'b0000_00) begin
            bad++;
            $display("FAIL arst_async got=%b/%0d exp=0000/0", outs(), rst_cause_o);
        end
        tick(); tick();
        arst_i = 1'b1;
        run_seq("arst_reseq", 24, 0);
    endtask

    initial begin
        test_reset();
        test_por_seq();
        test_sw_in_run();
        test_ext_glitch();
        test_ext_hold();
        test_simul_sw_wdt();
        test_wdt_in_hold();
        test_arst_mid_rel_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
